// File: rtl/std_pipe_reg.sv
// std_pipe_reg: DEPTH-stage elastic valid/ready pipeline register with bubble collapsing
// and occupancy count. Define STD_PIPE_REG_FLUSH_EN to add a synchronous flush input.
module std_pipe_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef STD_PIPE_REG_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic w_flush;
`ifdef STD_PIPE_REG_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused  = clk ^ rst_n ^ w_flush;
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign occupancy = '0;
  end else begin : g_pipe
    logic [DEPTH-1:0] w_vld;
    logic [DEPTH-1:0] w_rdy;
    logic [WIDTH-1:0] w_dat [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_fire;
    logic             w_out_fire;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      logic             r_vld;
      logic [WIDTH-1:0] r_dat;
      logic             w_up_vld;
      logic [WIDTH-1:0] w_up_dat;

      if (s == 0) begin : g_head
        assign w_up_vld = in_valid;
        assign w_up_dat = in_data;
      end else begin : g_body
        assign w_up_vld = w_vld[s-1];
        assign w_up_dat = w_dat[s-1];
      end

      // Ready chain unrolled: a stage may load when any stage at or after it is empty.
      assign w_rdy[s] = out_ready | ~(&w_vld[DEPTH-1:s]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_vld <= 1'b0;
        else if (w_flush)  r_vld <= 1'b0;
        else if (w_rdy[s]) r_vld <= w_up_vld;
      end

      always_ff @(posedge clk) begin
        if (w_rdy[s] && w_up_vld) r_dat <= w_up_dat;
      end

      assign w_vld[s] = r_vld;
      assign w_dat[s] = r_dat;
    end

    assign in_ready   = w_rdy[0];
    assign out_valid  = w_vld[DEPTH-1];
    assign out_data   = w_dat[DEPTH-1];
    assign w_in_fire  = in_valid & w_rdy[0];
    assign w_out_fire = w_vld[DEPTH-1] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_cnt <= '0;
      else if (w_flush) r_cnt <= '0;
      else              r_cnt <= r_cnt + CNT_W'(w_in_fire) - CNT_W'(w_out_fire);
    end

    assign occupancy = r_cnt;
  end

endmodule

// File: tb/tb_std_pipe_reg.sv
// Bench for std_pipe_reg: DEPTH=3 and DEPTH=0 instances checked every cycle against a
// compacting-queue model, plus directed scenarios with literal expectations.
module tb_std_pipe_reg;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = '0;

  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic       in_ready0, out_valid0;
  logic [7:0] out_data0;
  logic       occupancy0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  std_pipe_reg #(.WIDTH(8), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef STD_PIPE_REG_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  std_pipe_reg #(.WIDTH(8), .DEPTH(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef STD_PIPE_REG_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ordered list of beats, each with the stage index it currently sits in.
  typedef struct { logic [7:0] d; int pos; } beat_t;
  beat_t q[$];
  logic       s_in_fire = 1'b0, s_out_fire = 1'b0, s_flush = 1'b0;
  logic [7:0] s_data = '0;

  always @(negedge clk) begin : compare
    logic exp_ov, exp_ir;
    if (!rst_n) q.delete();
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (q[0].pos == D - 1);
    exp_ir = out_ready || (q.size() < D);
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, exp_ov);
    check("occupancy", occupancy, q.size());
    if (exp_ov) check("out_data", out_data, q[0].d);
    check("d0_in_ready", in_ready0, out_ready);
    check("d0_out_valid", out_valid0, in_valid);
    check("d0_out_data", out_data0, in_data);
    check("d0_occupancy", occupancy0, 0);
    s_in_fire  = rst_n && in_valid && exp_ir;
    s_out_fire = rst_n && exp_ov && out_ready;
    s_flush    = rst_n && flush;
    s_data     = in_data;
  end

  always @(posedge clk) begin : model
    beat_t b;
    int    lim;
    if (!rst_n) q.delete();
    else begin
      if (s_out_fire) void'(q.pop_front());
      if (s_flush) q.delete();
      else begin
        for (int k = 0; k < q.size(); k++) begin
          b   = q[k];
          lim = D - 1 - k;
          b.pos = (b.pos + 1 < lim) ? b.pos + 1 : lim;
          q[k] = b;
        end
        if (s_in_fire) begin
          b.d = s_data;
          b.pos = 0;
          q.push_back(b);
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    @(posedge clk); #1;
    in_valid = v; in_data = d; out_ready = r;
    @(negedge clk);
  endtask

  initial begin
    cyc(0, 8'h00, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Stream 0x01..0x05 at full rate
    for (int k = 1; k <= 9; k++) begin
      if (k <= 5) cyc(1, 8'(k), 1); else cyc(0, 8'h00, 1);
      check("t1_out_valid", out_valid, (k >= 4 && k <= 8));
      if (k >= 4 && k <= 8) check("t1_out_data", out_data, k - 3);
      if (k >= 4 && k <= 6) check("t1_occupancy", occupancy, 3);
    end

    // Stall fill then drain in order
    cyc(1, 8'hA1, 0); cyc(1, 8'hA2, 0); cyc(1, 8'hA3, 0); cyc(1, 8'hA4, 0);
    check("t2_in_ready_full", in_ready, 0);
    check("t2_occupancy", occupancy, 3);
    check("t2_head", out_data, 8'hA1);
    cyc(0, 8'h00, 1); check("t2_out0", out_data, 8'hA1);
    cyc(0, 8'h00, 1); check("t2_out1", out_data, 8'hA2);
    cyc(0, 8'h00, 1); check("t2_out2", out_data, 8'hA3);
    cyc(0, 8'h00, 1); check("t2_empty", out_valid, 0);

    // Bubble collapse under stall
    cyc(1, 8'h11, 0); cyc(0, 8'h00, 0); cyc(1, 8'h22, 0); cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    check("t3_occupancy", occupancy, 2);
    check("t3_in_ready", in_ready, 1);
    check("t3_head", out_data, 8'h11);
    cyc(0, 8'h00, 1); check("t3_out0", out_data, 8'h11);
    cyc(0, 8'h00, 1); check("t3_out1", out_data, 8'h22);
    cyc(0, 8'h00, 1); check("t3_empty", out_valid, 0);

    // Full pipe, simultaneous push and pop
    cyc(1, 8'hB1, 0); cyc(1, 8'hB2, 0); cyc(1, 8'hB3, 0);
    cyc(1, 8'h55, 1);
    check("t4_in_ready", in_ready, 1);
    check("t4_occupancy", occupancy, 3);
    cyc(0, 8'h00, 1); check("t4_occ_kept", occupancy, 3); check("t4_b2", out_data, 8'hB2);
    cyc(0, 8'h00, 1); check("t4_b3", out_data, 8'hB3);
    cyc(0, 8'h00, 1); check("t4_55", out_data, 8'h55);
    cyc(0, 8'h00, 1); check("t4_empty", out_valid, 0);

    // Asynchronous reset with two beats in flight
    cyc(1, 8'hC1, 0); cyc(1, 8'hC2, 0); cyc(0, 8'h00, 0);
    check("t5_occ_before", occupancy, 2);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_occupancy", occupancy, 0);
    check("t5_rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) cyc(1, 8'h77, 1); else cyc(0, 8'h00, 1);
      check("t5_out_valid", out_valid, (k == 4));
      if (k == 4) check("t5_out_data", out_data, 8'h77);
    end

`ifdef STD_PIPE_REG_FLUSH_EN
    cyc(1, 8'hD1, 0); cyc(1, 8'hD2, 0); cyc(1, 8'hD3, 0);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    @(negedge clk);
    check("t6_occ_pre", occupancy, 3);
    check("t6_in_ready", in_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("t6_occ_post", occupancy, 0);
    check("t6_out_valid", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 8'h00, 1);
      check("t6_no_ghost", out_valid, 0);
    end
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      in_data   = 8'($urandom);
      out_ready = ($urandom % 3) != 0;
`ifdef STD_PIPE_REG_FLUSH_EN
      flush     = ($urandom % 32) == 0;
`endif
      @(negedge clk);
    end
    @(posedge clk); #1 flush = 1'b0;
    for (int k = 0; k < 6; k++) cyc(0, 8'h00, 1);
    check("final_empty", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
